// File: rtl/uart_program_loader_if.sv
// Signal bundle between the UART byte stream, the program loader and the
// instruction memory write port / core stall.
interface uart_program_loader_if;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic        o_we;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic        o_core_hold;
  logic        o_done;
  logic        o_error;

  modport master (
    input  i_rx_data, i_rx_valid,
    output o_we, o_addr, o_wdata, o_core_hold, o_done, o_error
  );

  modport slave (
    output i_rx_data, i_rx_valid,
    input  o_we, o_addr, o_wdata, o_core_hold, o_done, o_error
  );
endinterface

// File: rtl/uart_program_loader.sv
// Parses SYNC/LEN/payload/CSUM frames from a UART byte stream into instruction memory writes.
// Optional inter-byte timeout is built only when LOADER_TIMEOUT_EN is defined.
module uart_program_loader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  uart_program_loader_if.master io_ldr
);
  localparam int unsigned IW      = ADDR_WIDTH + 1;
  localparam logic [31:0] MAX_LEN = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [15:0]           r_len;
  logic [IW-1:0]         r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [7:0]            r_csum;
  logic [23:0]           r_shift;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [7:0]  w_rx_byte;
  logic        w_rx_valid;
  logic        w_is_sync;
  logic [15:0] w_len;
  logic        w_word_done;
  logic        w_last_word;
  logic        w_timeout;

  assign w_rx_byte   = io_ldr.i_rx_data;
  assign w_rx_valid  = io_ldr.i_rx_valid;
  assign w_is_sync   = (w_rx_byte == SYNC_BYTE);
  assign w_len       = {w_rx_byte, r_len[7:0]};
  assign w_word_done = (r_byte_idx == 2'd3);
  assign w_last_word = ((32'(r_word_idx) + 32'd1) == {16'h0000, r_len});

`ifdef LOADER_TIMEOUT_EN
  logic [23:0] r_timer;
  logic        w_frame_active;

  assign w_frame_active = (r_state == ST_LEN_LO) || (r_state == ST_LEN_HI) ||
                          (r_state == ST_DATA)   || (r_state == ST_CSUM);

  // Counts idle cycles between bytes; frozen outside a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer <= '0;
    end else if (w_rx_valid) begin
      r_timer <= '0;
    end else if (w_frame_active) begin
      r_timer <= r_timer + 24'd1;
    end
  end

  assign w_timeout = w_frame_active && (r_timer >= TIMEOUT_CYCLES);
`else
  logic [23:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_rx_valid) begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (w_is_sync) begin
            w_state_next = ST_LEN_LO;
          end
        end
        ST_LEN_LO: w_state_next = ST_LEN_HI;
        ST_LEN_HI: begin
          if (w_len == 16'd0) begin
            w_state_next = ST_CSUM;
          end else if ({16'h0000, w_len} > MAX_LEN) begin
            w_state_next = ST_ERROR;
          end else begin
            w_state_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_word_done && w_last_word) begin
            w_state_next = ST_CSUM;
          end
        end
        ST_CSUM:  w_state_next = (w_rx_byte == r_csum) ? ST_DONE : ST_ERROR;
        default:  w_state_next = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_next = ST_ERROR;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_csum     <= '0;
      r_shift    <= '0;
      r_we       <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_rx_valid) begin
        case (r_state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (w_is_sync) begin
              r_len      <= '0;
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_csum     <= '0;
            end
          end
          ST_LEN_LO: r_len <= {8'h00, w_rx_byte};
          ST_LEN_HI: r_len <= w_len;
          ST_DATA: begin
            r_csum     <= r_csum + w_rx_byte;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0:    r_shift[7:0]   <= w_rx_byte;
              2'd1:    r_shift[15:8]  <= w_rx_byte;
              2'd2:    r_shift[23:16] <= w_rx_byte;
              default: ;
            endcase
            // Fourth byte completes the word; the write issues next cycle.
            if (w_word_done) begin
              r_we       <= 1'b1;
              r_wdata    <= {w_rx_byte, r_shift};
              r_addr     <= BASE_ADDR + 32'({r_word_idx, 2'b00});
              r_word_idx <= r_word_idx + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_ldr.o_we        = r_we;
  assign io_ldr.o_addr      = r_addr;
  assign io_ldr.o_wdata     = r_wdata;
  assign io_ldr.o_done      = (r_state == ST_DONE);
  assign io_ldr.o_error     = (r_state == ST_ERROR);
  assign io_ldr.o_core_hold = (r_state != ST_DONE);
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: table vectors, hand-written corner sequences and
// random frames checked against a payload-to-word model.
`timescale 1ns/1ps
module tb_uart_program_loader;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic clk = 1'b0;
  logic rst;

  uart_program_loader_if ldr_if();

  uart_program_loader #(
    .ADDR_WIDTH    (10),
    .BASE_ADDR     (BASE),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_ldr(ldr_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_q[$];
  logic [7:0]  pl_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] cap_q[$];

  // Every memory write seen by the bench, as {addr, data}.
  always @(negedge clk) begin
    if (ldr_if.o_we === 1'b1) cap_q.push_back({ldr_if.o_addr, ldr_if.o_wdata});
  end

  typedef struct packed {
    logic [7:0]   nb;
    logic [127:0] bytes;  // first byte sent sits in the highest used byte lane
    logic [1:0]   nw;
    logic [63:0]  words;  // word 0 in [31:0]
    logic         done;
    logic         err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    ldr_if.i_rx_data  = b;
    ldr_if.i_rx_valid = 1'b1;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge clk);
      ldr_if.i_rx_valid = 1'b0;
    end
  endtask

  task automatic send_tx(input bit gaps);
    foreach (tx_q[i]) begin
      put_byte(tx_q[i]);
      if (gaps && ($urandom_range(0, 1) == 1)) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
  endtask

  // Payload bytes grouped four at a time, little-endian, at consecutive word addresses.
  task automatic model_from_payload();
    exp_q.delete();
    for (int w = 0; w < pl_q.size() / 4; w++) begin
      exp_q.push_back({BASE + 32'(4 * w), pl_q[4*w+3], pl_q[4*w+2], pl_q[4*w+1], pl_q[4*w]});
    end
  endtask

  task automatic verify(input string tag, input bit exp_done, input bit exp_err);
    check({tag, ".nwrites"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), cap_q[i][63:32], exp_q[i][63:32]);
      check($sformatf("%s.data%0d", tag, i), cap_q[i][31:0], exp_q[i][31:0]);
    end
    check({tag, ".done"}, 32'(ldr_if.o_done), 32'(exp_done));
    check({tag, ".error"}, 32'(ldr_if.o_error), 32'(exp_err));
    check({tag, ".hold"}, 32'(ldr_if.o_core_hold), 32'(!exp_done));
    $display("frame %s: %0d writes, done=%0b error=%0b hold=%0b", tag, cap_q.size(),
             ldr_if.o_done, ldr_if.o_error, ldr_if.o_core_hold);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Checksum is the sum of payload bytes only: 93+00+10+00+13+01+20+00 = D7.
    vecs[0] = '{8'd8,  128'hA5_01_00_13_00_00_00_13, 2'd1, 64'h0000_0000_0000_0013, 1'b1, 1'b0};
    vecs[1] = '{8'd12, 128'hA5_02_00_93_00_10_00_13_01_20_00_D7, 2'd2, 64'h0020_0113_0010_0093, 1'b1, 1'b0};
    vecs[2] = '{8'd12, 128'hA5_02_00_93_00_10_00_13_01_20_00_D8, 2'd2, 64'h0020_0113_0010_0093, 1'b0, 1'b1};
    vecs[3] = '{8'd4,  128'hA5_00_00_00, 2'd0, 64'h0, 1'b1, 1'b0};
    vecs[4] = '{8'd3,  128'hA5_01_04, 2'd0, 64'h0, 1'b0, 1'b1};
    vecs[5] = '{8'd11, 128'h00_FF_5A_A5_01_00_78_56_34_12_14, 2'd1, 64'h0000_0000_1234_5678, 1'b1, 1'b0};

    rst = 1'b1;
    ldr_if.i_rx_data  = 8'h00;
    ldr_if.i_rx_valid = 1'b0;
    idle(3);
    check("rst.we", 32'(ldr_if.o_we), 32'd0);
    check("rst.addr", ldr_if.o_addr, BASE);
    check("rst.wdata", ldr_if.o_wdata, 32'd0);
    check("rst.hold", 32'(ldr_if.o_core_hold), 32'd1);
    check("rst.done", 32'(ldr_if.o_done), 32'd0);
    check("rst.error", 32'(ldr_if.o_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    for (int v = 0; v < 6; v++) begin
      vec_t tv;
      tv = vecs[v];
      tx_q.delete();
      exp_q.delete();
      cap_q.delete();
      for (int i = 0; i < int'(tv.nb); i++) tx_q.push_back(tv.bytes[8*(int'(tv.nb)-1-i) +: 8]);
      for (int w = 0; w < int'(tv.nw); w++) exp_q.push_back({BASE + 32'(4 * w), tv.words[32*w +: 32]});
      send_tx(v[0] == 1'b1);
      verify($sformatf("vec%0d", v), tv.done, tv.err);
    end

    // Write pulse lands exactly one cycle after the 4th byte; a byte in that cycle is kept.
    cap_q.delete();
    pl_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    model_from_payload();
    put_byte(8'hA5); put_byte(8'h01); put_byte(8'h00);
    put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC); put_byte(8'hDD);
    check("lat.early", 32'(ldr_if.o_we), 32'd0);
    put_byte(8'h0E);
    check("lat.we", 32'(ldr_if.o_we), 32'd1);
    check("lat.addr", ldr_if.o_addr, BASE);
    check("lat.wdata", ldr_if.o_wdata, 32'hDDCC_BBAA);
    idle(1);
    check("lat.pulse", 32'(ldr_if.o_we), 32'd0);
    idle(2);
    verify("latency", 1'b1, 1'b0);

    // Reset in the middle of the payload.
    tx_q = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    foreach (tx_q[i]) put_byte(tx_q[i]);
    @(negedge clk);
    rst = 1'b1;
    ldr_if.i_rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.hold", 32'(ldr_if.o_core_hold), 32'd1);
    check("midrst.done", 32'(ldr_if.o_done), 32'd0);
    check("midrst.error", 32'(ldr_if.o_error), 32'd0);
    check("midrst.addr", ldr_if.o_addr, BASE);
    put_byte(8'h00); put_byte(8'h13);
    idle(3);
    check("midrst.idle_done", 32'(ldr_if.o_done), 32'd0);
    check("midrst.idle_hold", 32'(ldr_if.o_core_hold), 32'd1);

    // Largest legal image, sent back-to-back.
    begin
      logic [7:0] sum;
      tx_q = {8'hA5, 8'h00, 8'h04};
      pl_q.delete();
      cap_q.delete();
      sum = 8'h00;
      for (int i = 0; i < 4096; i++) begin
        logic [7:0] b;
        b = 8'((i * 7 + 3) ^ (i >> 8));
        pl_q.push_back(b);
        tx_q.push_back(b);
        sum = sum + b;
      end
      tx_q.push_back(sum);
      model_from_payload();
      send_tx(1'b0);
      verify("maxlen", 1'b1, 1'b0);
    end

    // Random frames: optional garbage, random length and payload, mostly-good checksum.
    for (int f = 0; f < 25; f++) begin
      int len;
      bit good;
      logic [7:0] sum;
      tx_q.delete();
      pl_q.delete();
      cap_q.delete();
      sum = 8'h00;
      repeat ($urandom_range(0, 3)) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        tx_q.push_back(g);
      end
      len = int'($urandom_range(0, 6));
      tx_q.push_back(8'hA5);
      tx_q.push_back(8'(len));
      tx_q.push_back(8'h00);
      for (int i = 0; i < len * 4; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        pl_q.push_back(b);
        tx_q.push_back(b);
        sum = sum + b;
      end
      good = ($urandom_range(0, 3) != 0);
      tx_q.push_back(good ? sum : (sum ^ 8'($urandom_range(1, 255))));
      model_from_payload();
      send_tx(f[0] == 1'b1);
      verify($sformatf("rnd%0d", f), good, !good);
    end

`ifdef LOADER_TIMEOUT_EN
    // Frame stalls inside DATA; error follows 101 cycles after the last byte.
    put_byte(8'hA5); put_byte(8'h01); put_byte(8'h00); put_byte(8'h13);
    idle(101);
    check("tmo.before", 32'(ldr_if.o_error), 32'd0);
    idle(1);
    check("tmo.error", 32'(ldr_if.o_error), 32'd1);
    check("tmo.hold", 32'(ldr_if.o_core_hold), 32'd1);
    check("tmo.done", 32'(ldr_if.o_done), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
